// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage constants: vectors, redirect priorities, PC FSM encoding
package cpu_pkg;

    localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VECTOR_DEF   = 32'h0000_4180;

    typedef logic [1:0] prio_t;

    localparam prio_t PRIO_BR   = 2'd0;
    localparam prio_t PRIO_ERET = 2'd1;
    localparam prio_t PRIO_EXC  = 2'd2;

    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_PEND = 1'b1;

endpackage

// File: rtl/pc_redirect_slot.sv
// rtl/pc_redirect_slot.sv - one-entry pending redirect register, overwritten only by a strictly higher priority
module pc_redirect_slot
    import cpu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             offer,
    input  prio_t            offer_prio,
    input  logic [WIDTH-1:0] offer_target,
    output logic [WIDTH-1:0] slot_target
);

    logic  slot_valid;
    prio_t slot_prio;
    logic  accept;

    // An empty slot takes any offer; a full one keeps the older request on a tie.
    assign accept = offer && (!slot_valid || (offer_prio > slot_prio));

    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_valid  <= 1'b0;
            slot_prio   <= PRIO_BR;
            slot_target <= '0;
        end else if (clear) begin
            slot_valid  <= 1'b0;
            slot_prio   <= PRIO_BR;
        end else if (accept) begin
            slot_valid  <= 1'b1;
            slot_prio   <= offer_prio;
            slot_target <= offer_target;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch program counter with prioritised redirects and a pending slot for held cycles
module pc_unit
    import cpu_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEF),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(EXC_VECTOR_DEF),
    parameter int               BUSY_W       = 3,
    parameter int               STEP         = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_data,
    input  logic [BUSY_W-1:0] busy,
    input  logic              br_valid,
    input  logic [WIDTH-1:0]  br_target,
    input  logic              eret_req,
    input  logic [WIDTH-1:0]  epc,
    input  logic              exc_req,
    output logic [WIDTH-1:0]  pc,
    output logic [WIDTH-1:0]  pc_plus,
    output logic              pend_valid,
    output logic              misalign
);

    logic             hold;
    logic             req_live;
    prio_t            req_prio;
    logic [WIDTH-1:0] req_target;
    logic [0:0]       state;
    logic [WIDTH-1:0] slot_target;
    logic             slot_clear;
    logic             slot_offer;

    assign hold = stall_data | (|busy);

    // Exceptions never pend, so only eret and branch compete for the slot.
    assign req_live   = eret_req | br_valid;
    assign req_prio   = eret_req ? PRIO_ERET : PRIO_BR;
    assign req_target = eret_req ? epc : br_target;

    assign slot_clear = exc_req | ((state == ST_PEND) & ~hold);
    assign slot_offer = req_live & hold & ~exc_req;

    pc_redirect_slot #(
        .WIDTH(WIDTH)
    ) u_slot (
        .clk         (clk),
        .reset       (reset),
        .clear       (slot_clear),
        .offer       (slot_offer),
        .offer_prio  (req_prio),
        .offer_target(req_target),
        .slot_target (slot_target)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc    <= RESET_VECTOR;
            state <= ST_RUN;
        end else if (exc_req) begin
            pc    <= EXC_VECTOR;
            state <= ST_RUN;
        end else begin
            case (state)
                ST_RUN: begin
                    if (!hold) begin
                        pc <= req_live ? req_target : pc_plus;
                    end else if (req_live) begin
                        state <= ST_PEND;
                    end
                end
                default: begin
                    // Release edge: requests arriving now are dropped in favour of the pended one.
                    if (!hold) begin
                        pc    <= slot_target;
                        state <= ST_RUN;
                    end
                end
            endcase
        end
    end

    assign pc_plus    = pc + WIDTH'(STEP);
    assign pend_valid = (state == ST_PEND);
    assign misalign   = |pc[1:0];

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed vector table plus randomized run against a behavioural PC model
module tb_pc_unit;

    localparam logic [31:0] RV  = 32'h0000_3000;
    localparam logic [31:0] EV  = 32'h0000_4180;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_data;
    logic [2:0]  busy;
    logic        br_valid;
    logic [31:0] br_target;
    logic        eret_req;
    logic [31:0] epc;
    logic        exc_req;
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic        pend_valid;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pc_unit #(
        .WIDTH       (32),
        .RESET_VECTOR(RV),
        .EXC_VECTOR  (EV),
        .BUSY_W      (3),
        .STEP        (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall_data(stall_data),
        .busy      (busy),
        .br_valid  (br_valid),
        .br_target (br_target),
        .eret_req  (eret_req),
        .epc       (epc),
        .exc_req   (exc_req),
        .pc        (pc),
        .pc_plus   (pc_plus),
        .pend_valid(pend_valid),
        .misalign  (misalign)
    );

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic [2:0]  busy;
        logic        br;
        logic [31:0] brt;
        logic        eret;
        logic [31:0] epc;
        logic        exc;
        logic [31:0] exp_pc;
        logic        exp_pend;
    } vec_t;

    vec_t vecs[$];

    logic [31:0] m_pc;
    logic        m_pend;
    logic [31:0] m_ptgt;
    int          m_pprio;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic s, input logic [2:0] b, input logic br,
                       input logic [31:0] brt, input logic er, input logic [31:0] e,
                       input logic x, input logic [31:0] xpc, input logic xpend);
        vec_t v;
        v.rst_n = r; v.stall = s; v.busy = b; v.br = br; v.brt = brt;
        v.eret = er; v.epc = e; v.exc = x; v.exp_pc = xpc; v.exp_pend = xpend;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic s, input logic [2:0] b, input logic br,
                         input logic [31:0] brt, input logic er, input logic [31:0] e, input logic x);
        reset = r; stall_data = s; busy = b; br_valid = br; br_target = brt;
        eret_req = er; epc = e; exc_req = x;
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] xpc, input logic xpend);
        chk({tag, " pc"}, pc, xpc);
        chk({tag, " pend_valid"}, {31'b0, pend_valid}, {31'b0, xpend});
        chk({tag, " misalign"}, {31'b0, misalign}, {31'b0, (xpc % 4) != 0});
        chk({tag, " pc_plus"}, pc_plus, xpc + 32'd4);
    endtask

    // Rules of the fetch PC applied to one clock edge, using the currently driven inputs.
    task automatic model_step();
        bit          held;
        bit          live;
        int          prio;
        logic [31:0] tgt;
        held = stall_data || (busy != 0);
        live = eret_req || br_valid;
        prio = eret_req ? 1 : 0;
        tgt  = eret_req ? epc : br_target;
        if (!reset) begin
            m_pc = RV; m_pend = 0;
        end else if (exc_req) begin
            m_pc = EV; m_pend = 0;
        end else if (!m_pend) begin
            if (!held) m_pc = live ? tgt : m_pc + 32'd4;
            else if (live) begin m_pend = 1; m_ptgt = tgt; m_pprio = prio; end
        end else begin
            if (!held) begin m_pc = m_ptgt; m_pend = 0; end
            else if (live && prio > m_pprio) begin m_ptgt = tgt; m_pprio = prio; end
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 3'b000, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

        //   rst stall busy    br  brt           eret epc          exc  exp_pc        pend
        add(0, 0, 3'b000, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3000, 0);
        add(1, 0, 3'b000, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3004, 0);
        add(1, 0, 3'b000, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3008, 0);
        add(1, 0, 3'b010, 1, 32'h3100,     0, 32'h0,        0, 32'h0000_3008, 1);
        add(1, 0, 3'b010, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3008, 1);
        add(1, 0, 3'b010, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3008, 1);
        add(1, 0, 3'b000, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3100, 0);
        add(1, 1, 3'b000, 1, 32'h3100,     0, 32'h0,        0, 32'h0000_3100, 1);
        add(1, 1, 3'b000, 0, 32'h0,        1, 32'h3200,     0, 32'h0000_3100, 1);
        add(1, 1, 3'b000, 1, 32'h3300,     0, 32'h0,        0, 32'h0000_3100, 1);
        add(1, 0, 3'b000, 1, 32'h3600,     0, 32'h0,        0, 32'h0000_3200, 0);
        add(1, 1, 3'b000, 1, 32'h3500,     0, 32'h0,        0, 32'h0000_3200, 1);
        add(1, 1, 3'b000, 0, 32'h0,        0, 32'h0,        1, 32'h0000_4180, 0);
        add(1, 1, 3'b000, 0, 32'h0,        0, 32'h0,        0, 32'h0000_4180, 0);
        add(1, 0, 3'b000, 0, 32'h0,        0, 32'h0,        0, 32'h0000_4184, 0);
        add(1, 0, 3'b000, 1, 32'h3002,     0, 32'h0,        0, 32'h0000_3002, 0);
        add(1, 0, 3'b000, 1, 32'hFFFF_FFFC, 0, 32'h0,       0, 32'hFFFF_FFFC, 0);
        add(1, 0, 3'b000, 0, 32'h0,        0, 32'h0,        0, 32'h0000_0000, 0);
        add(1, 0, 3'b001, 1, 32'h3100,     0, 32'h0,        0, 32'h0000_0000, 1);
        add(0, 0, 3'b001, 0, 32'h0,        0, 32'h0,        1, 32'h0000_3000, 0);
        add(1, 0, 3'b000, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3004, 0);
        add(1, 1, 3'b000, 1, 32'h3400,     0, 32'h0,        0, 32'h0000_3004, 1);
        add(1, 0, 3'b000, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3400, 0);
        add(1, 1, 3'b000, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3400, 0);
        add(1, 0, 3'b000, 0, 32'h0,        0, 32'h0,        0, 32'h0000_3404, 0);

        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].stall, vecs[i].busy, vecs[i].br, vecs[i].brt,
                  vecs[i].eret, vecs[i].epc, vecs[i].exc);
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].exp_pc, vecs[i].exp_pend);
        end

        m_pc = 32'h0; m_pend = 0; m_ptgt = 32'h0; m_pprio = 0;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            t = $urandom();
            if (($urandom_range(0, 3)) != 0) t[1:0] = 2'b00;
            drive((i == 0) ? 1'b0 : ($urandom_range(0, 199) != 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
                  ($urandom_range(0, 3) == 0), t,
                  ($urandom_range(0, 7) == 0), {$urandom_range(0, 32'hFFFF), 2'b00},
                  ($urandom_range(0, 39) == 0));
            model_step();
            @(posedge clk);
            #1;
            check_outputs($sformatf("rand%0d", i), m_pc, m_pend);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
